// File: rtl/ysyx_25020037_icache.sv
// Direct-mapped read-only instruction cache with whole-line AXI4 INCR refill.
module ysyx_25020037_icache #(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        fence_i,
  input  logic        arready,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        rready,
  input  logic        rvalid,
  input  logic [1:0]  rresp,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  localparam int unsigned WOFF = $clog2(LINE_WORDS);
  localparam int unsigned OFF  = WOFF + 2;
  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - OFF - IDX;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [31:2]       addr_q;
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS][LINE_WORDS];
  logic              fence_pend_q;
  logic [WOFF-1:0]   cnt_q;
  logic              err_q;

  logic [IDX-1:0]    idx_c;
  logic [TAGW-1:0]   tag_c;
  logic [WOFF-1:0]   word_c;
  logic              hit_c;
  logic              beat_c;
  logic              last_beat_c;
  logic              fin_err_c;
  logic              unused_c;

  // Address decode of the latched fetch PC and lookup result
  assign idx_c       = addr_q[OFF+IDX-1:OFF];
  assign tag_c       = addr_q[31:OFF+IDX];
  assign word_c      = addr_q[OFF-1:2];
  assign hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  assign beat_c      = (state_q == S_R) && rvalid;
  assign last_beat_c = cnt_q == WOFF'(LINE_WORDS - 1);
  // Final refill status: any bad response so far, this beat's response, or a short burst
  assign fin_err_c   = err_q || (rresp != 2'b00) || !last_beat_c;
  assign unused_c    = ^{rid, req_addr[1:0]};

  // Handshake strobes decoded from the state; a fresh fence_i wins over a new request
  assign req_ready  = (state_q == S_IDLE) && !fence_pend_q && !fence_i;
  assign arvalid    = state_q == S_AR;
  assign rready     = state_q == S_R;
  assign resp_valid = state_q == S_RESP;
  assign arid       = 4'd0;
  assign arlen      = 8'(LINE_WORDS - 1);
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid && req_ready) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit_c ? S_RESP : S_AR;
      S_AR:     if (arready) state_d = S_R;
      S_R:      if (rvalid && rlast) state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, control flags, valid bits and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      fence_pend_q <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      araddr       <= '0;
      resp_inst    <= '0;
      resp_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fence_i) begin
        fence_pend_q <= 1'b1;
      end else if ((state_q == S_IDLE) && fence_pend_q) begin
        fence_pend_q <= 1'b0;
      end
      if ((state_q == S_IDLE) && fence_pend_q) valid_q <= '0;
      if (req_valid && req_ready) addr_q <= req_addr[31:2];
      if (state_q == S_LOOKUP) begin
        if (hit_c) begin
          resp_inst <= data_q[idx_c][word_c];
          resp_err  <= 1'b0;
        end else begin
          araddr <= {tag_c, idx_c, {OFF{1'b0}}};
        end
      end
      if (state_q == S_AR) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end
      if (beat_c) begin
        cnt_q <= WOFF'(cnt_q + 1'b1);
        // A non-final beat at the last slot means the burst overruns the line
        if ((rresp != 2'b00) || (last_beat_c && !rlast)) err_q <= 1'b1;
        if (cnt_q == word_c) resp_inst <= rdata;
        if (rlast) begin
          valid_q[idx_c] <= !fin_err_c;
          resp_err       <= fin_err_c;
        end
      end
    end
  end

  // Line data and tag storage, written only by refill beats
  always_ff @(posedge clk) begin
    if (beat_c) begin
      data_q[idx_c][cnt_q] <= rdata;
      if (rlast && !fin_err_c) tag_q[idx_c] <= tag_c;
    end
  end

endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// Directed self-checking bench for ysyx_25020037_icache (SETS=16, LINE_WORDS=4).
module tb_ysyx_25020037_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        fence_i = 1'b0;
  logic        arready = 1'b0;
  logic        arvalid;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready;
  logic        rvalid = 1'b0;
  logic [1:0]  rresp = 2'b00;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = 4'd0;

  int errors = 0;
  int checks = 0;

  ysyx_25020037_icache #(.SETS(16), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .fence_i(fence_i),
    .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request once req_ready is up; returns in the LOOKUP cycle
  task automatic request(input logic [31:0] addr);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
  endtask

  // From LOOKUP: expect a miss, serve the burst, check the response and consume it
  task automatic finish_miss(input logic [31:0] exp_araddr, input logic [31:0] d0,
                             input int bad_beat, input logic [31:0] exp_inst,
                             input logic exp_err);
    chk("lookup_no_ar", {31'd0, arvalid}, 32'd0);
    step();
    chk("ar_valid", {31'd0, arvalid}, 32'd1);
    chk("ar_addr", araddr, exp_araddr);
    step();
    chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
    chk("ar_hold_addr", araddr, exp_araddr);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r_ready", {31'd0, rready}, 32'd1);
    chk("ar_dropped", {31'd0, arvalid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata  = d0 * 32'(i + 1);
      rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      rlast  = (i == 3);
      step();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    chk("miss_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("miss_resp_inst", resp_inst, exp_inst);
    chk("miss_resp_err", {31'd0, resp_err}, {31'd0, exp_err});
    consume();
  endtask

  // From LOOKUP: expect a hit with response in the next cycle
  task automatic finish_hit(input logic [31:0] exp_inst);
    step();
    chk("hit_no_ar", {31'd0, arvalid}, 32'd0);
    chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_resp_inst", resp_inst, exp_inst);
    chk("hit_resp_err", {31'd0, resp_err}, 32'd0);
    consume();
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_consumed", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    // Reset values
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_inst", resp_inst, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("arlen", {24'd0, arlen}, 32'd3);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);

    // Cold miss, then hits in the same line
    request(32'h3000_0004);
    finish_miss(32'h3000_0000, 32'h11, -1, 32'h22, 1'b0);
    request(32'h3000_000C);
    finish_hit(32'h44);
    request(32'h3000_0000);
    finish_hit(32'h11);

    // Conflict on index 0 evicts the first line
    request(32'h3000_0104);
    finish_miss(32'h3000_0100, 32'h101, -1, 32'h202, 1'b0);
    request(32'h3000_0004);
    finish_miss(32'h3000_0000, 32'h11, -1, 32'h22, 1'b0);

    // Bad response on beat 1: error reported, line left invalid
    request(32'h3000_0208);
    finish_miss(32'h3000_0200, 32'h1000, 1, 32'h3000, 1'b1);
    request(32'h3000_0208);
    finish_miss(32'h3000_0200, 32'h1000, -1, 32'h3000, 1'b0);

    // Fence pulse while in RESP
    request(32'h3000_0208);
    step();
    chk("fence_resp_hit", {31'd0, resp_valid}, 32'd1);
    fence_i = 1'b1;
    step();
    fence_i = 1'b0;
    chk("fence_resp_held", {31'd0, resp_valid}, 32'd1);
    consume();
    chk("fence_idle_block", {31'd0, req_ready}, 32'd0);
    step();
    chk("fence_idle_release", {31'd0, req_ready}, 32'd1);
    request(32'h3000_0208);
    finish_miss(32'h3000_0200, 32'h1000, -1, 32'h3000, 1'b0);

    // Fence and request together in IDLE: fence first, request afterwards misses
    fence_i   = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h3000_0208;
    step();
    fence_i = 1'b0;
    chk("fence_req_block", {31'd0, req_ready}, 32'd0);
    chk("fence_req_no_resp", {31'd0, resp_valid}, 32'd0);
    step();
    chk("fence_req_accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    finish_miss(32'h3000_0200, 32'h1000, -1, 32'h3000, 1'b0);

    // Back-pressure holds the response
    request(32'h3000_0208);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_inst", resp_inst, 32'h3000);
      step();
    end
    consume();

    // Asynchronous reset in the middle of a burst
    request(32'h3000_0304);
    step();
    chk("mid_ar_valid", {31'd0, arvalid}, 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = 32'hdead_0001;
    step();
    rdata = 32'hdead_0002;
    rst   = 1'b1;
    #1;
    chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("arst_rready", {31'd0, rready}, 32'd0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rvalid = 1'b0;
    step();
    rst = 1'b0;
    step();
    request(32'h3000_0208);
    finish_miss(32'h3000_0200, 32'h1000, -1, 32'h3000, 1'b0);
    request(32'h3000_0304);
    finish_miss(32'h3000_0300, 32'h7, -1, 32'he, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_icache.md
# ysyx_25020037_icache

Direct-mapped, read-only instruction cache between the IFU fetch logic and the IFU read port of the core-soc AXI arbiter. Hits are served from internal register arrays. Misses refill a whole line with one AXI4 INCR burst read through the arbiter's `ifu_ar*`/`ifu_r*` channels. A `fence_i` pulse invalidates every line.

## Interface
Parameters:
- `SETS`, 16: number of lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, 2..16.

Address split:
- OFF = log2(LINE_WORDS)+2
- IDX = log2(SETS)
- offset = `[OFF-1:0]`, index = `[OFF+IDX-1:OFF]`, tag = `[31:OFF+IDX]`

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: fetch request from IFU.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_addr` in 32: fetch PC; bits `[1:0]` ignored.
- `resp_valid` out 1: instruction available.
- `resp_ready` in 1: IFU consumes response.
- `resp_inst` out 32: fetched instruction.
- `resp_err` out 1: bus error occurred during refill.
- `fence_i` in 1: invalidate-all request (pulse).
- `arready` in 1: AXI AR ready from arbiter.
- `arvalid` out 1: AXI AR valid.
- `araddr` out 32: line-aligned address.
- `arid` out 4: constant 0.
- `arlen` out 8: LINE_WORDS-1.
- `arsize` out 3: 3'b010.
- `arburst` out 2: 2'b01 (INCR).
- `rready` out 1: AXI R ready.
- `rvalid` in 1: AXI R valid.
- `rresp` in 2: AXI R response.
- `rdata` in 32: AXI R data.
- `rlast` in 1: last beat of burst.
- `rid` in 4: ignored.

## Operation
- Storage: per line a valid bit, a tag, and LINE_WORDS data words, held in flip-flops with combinational read.
- FSM states:
  - IDLE: `req_ready` = !`fence_pend`. On accept, latch `req_addr` and go to LOOKUP.
  - LOOKUP: hit = valid[idx] & tag match.
    - On hit, load `resp_inst` with word[offset>>2], `resp_err`=0, go to RESP.
    - On miss, go to AR.
  - AR: `arvalid`=1, `araddr` = {tag, idx, OFF'b0}. On `arready`, go to R.
    - `araddr`, `arlen`, `arsize` and `arburst` are stable while `arvalid` is high.
    - Beat counter is cleared to 0.
  - R: `rready`=1. Each `rvalid` beat:
    - writes data word[cnt] of line idx and increments cnt;
    - ORs (`rresp`≠0) into the error flag;
    - if cnt equals the requested word, captures `rdata` into `resp_inst`.
  - R, on the `rlast` beat:
    - an error is also flagged if cnt≠LINE_WORDS-1;
    - without error, set valid[idx] and write the tag;
    - with error, clear valid[idx];
    - `resp_err` = error flag; go to RESP.
  - RESP: `resp_valid`=1; `resp_inst`/`resp_err` are held stable until `resp_ready`, then go to IDLE.
- `fence_i`:
  - A pulse in any state sets `fence_pend`.
  - In IDLE with `fence_pend`=1, all valid bits clear in one cycle, `fence_pend` clears, and no request is accepted that cycle.
  - `fence_i` and `req_valid` together in IDLE: the fence wins and the request waits.
- Beats received while not in R are impossible by protocol; `rready`=0 there.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; `fence_pend` 0.
  - `req_ready`=1 (after reset deassertion).
  - `resp_valid`, `resp_err` = 0; `resp_inst` = 0.
  - `arvalid`, `rready` = 0; `araddr` = 0.
  - Constant outputs `arid`, `arlen`, `arsize`, `arburst` hold their fixed values at all times.
- Reset mid-refill: everything returns to the reset values immediately, asynchronously. The partial line is not valid. The arbiter is reset by the same `rst`.
- Hit latency: request accepted in cycle T, LOOKUP in T+1, `resp_valid` in T+2. Best-case throughput is one fetch per 3 cycles with `resp_ready` held at 1.
- Miss latency: `arvalid` first high in T+2. With the final (`rlast`) beat in cycle B, `resp_valid` is high in B+1.
- `req_ready` is 1 only in IDLE. Back-to-back requests are not overlapped.
- Only one AXI transaction is outstanding at a time. `arvalid` never drops before `arready`.

## Test plan
Settings: SETS=16, LINE_WORDS=4 (index `[7:4]`, tag `[31:8]`). Each case has stimulus, then required response.
- Cold miss `req_addr`=0x30000004:
  - AR fields: `araddr`=0x30000000, `arlen`=3, `arsize`=2, `arburst`=1.
  - Beats 0x11,0x22,0x33,0x44 with `rresp`=0.
  - Response: `resp_inst`=0x22, `resp_err`=0, `resp_valid` one cycle after the `rlast` beat.
- Hit, then request 0x3000000C:
  - No `arvalid` is issued.
  - `resp_inst`=0x44 in T+2.
- Conflict, then request 0x30000104 (same index, new tag):
  - refill issued at 0x30000100;
  - a following request for 0x30000004 misses again.
- Error on refill (`rresp`=2'b10 on beat 1):
  - `resp_err`=1;
  - a repeat request for the same address re-issues AR.
- `fence_i` pulse while in RESP, then request 0x30000004:
  - `req_ready` is low for one IDLE cycle;
  - the request then misses.
- Back-pressure and reset:
  - `resp_ready`=0 for 5 cycles: `resp_inst` is held stable.
  - `rst` asserted mid-burst: `arvalid`/`rready`/`resp_valid`=0 at once, and every line misses afterwards.
